// File: rtl/trace_pkt_sched.sv
// trace_pkt_sched: assembles 8-word trace frames into a slot ring and drains them over valid/ready.
// Define TRACE_PKT_SCHED_OVFCNT_EN to build the saturating ovfCount/badCount counters.
module trace_pkt_sched #(
    parameter int SLOTBITS = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                WdAvail,
    input  logic [15:0]         PacketWd,
    input  logic                PacketReset,
    input  logic                PacketCommit,
    input  logic                sync,
    output logic                FrameValid,
    output logic [15:0]         FrameWd,
    output logic                FrameLast,
    input  logic                FrameReady,
    output logic [SLOTBITS:0]   slotsUsed,
    output logic [15:0]         ovfCount,
    output logic [7:0]          badCount
);
    localparam int NSLOT = 1 << SLOTBITS;

    typedef enum logic {IDLE, SEND} state_t;

    logic [15:0]         mem [NSLOT][8];
    logic [SLOTBITS-1:0] wrSlot, rdSlot;
    logic [3:0]          wrIdx;
    logic [2:0]          rdIdx;
    logic                drop, malformed;
    state_t              state, nextState;
    logic                clear, commit, wordIn, full, wrEn, goodCommit, beat, slotRelease;

    assign clear       = !sync || PacketReset;
    assign commit      = !clear && PacketCommit;
    assign wordIn      = !clear && !PacketCommit && WdAvail;
    assign full        = slotsUsed == (SLOTBITS+1)'(NSLOT);
    // A frame may only start into a free slot, so an undrained slot is never overwritten.
    assign wrEn        = wordIn && !(wrIdx == 4'd0 && full) && !drop && !wrIdx[3];
    assign goodCommit  = commit && !drop && wrIdx == 4'd8 && !malformed;
    assign beat        = FrameValid && FrameReady;
    assign slotRelease = beat && rdIdx == 3'd7;

    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            wrSlot    <= '0;
            wrIdx     <= '0;
            drop      <= 1'b0;
            malformed <= 1'b0;
        end else if (clear || commit) begin
            wrIdx     <= '0;
            drop      <= 1'b0;
            malformed <= 1'b0;
            if (goodCommit) wrSlot <= wrSlot + 1'b1;
        end else if (wordIn) begin
            if (wrIdx == 4'd0 && full) drop <= 1'b1;
            else if (!drop && !wrIdx[3]) wrIdx <= wrIdx + 4'd1;
            else if (wrIdx[3]) malformed <= 1'b1;
        end

    always_ff @(posedge clk)
        if (wrEn) mem[wrSlot][wrIdx[2:0]] <= PacketWd;

    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            rdSlot    <= '0;
            rdIdx     <= '0;
            slotsUsed <= '0;
        end else begin
            if (beat) rdIdx <= rdIdx + 3'd1;
            if (slotRelease) rdSlot <= rdSlot + 1'b1;
            slotsUsed <= slotsUsed + (SLOTBITS+1)'(goodCommit) - (SLOTBITS+1)'(slotRelease);
        end

    always_ff @(posedge clk or negedge rst)
        if (!rst) state <= IDLE;
        else state <= nextState;

    always_comb
        nextState = state == IDLE ? (slotsUsed != '0 ? SEND : IDLE)
                  : (slotRelease && slotsUsed == (SLOTBITS+1)'(1) && !goodCommit) ? IDLE : SEND;

    always_comb begin
        FrameValid = state == SEND;
        FrameLast  = state == SEND && rdIdx == 3'd7;
        FrameWd    = mem[rdSlot][rdIdx];
    end

`ifdef TRACE_PKT_SCHED_OVFCNT_EN
    logic ovfEvt, badEvt;
    assign ovfEvt = commit && drop;
    assign badEvt = commit && !drop && !goodCommit;

    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            ovfCount <= '0;
            badCount <= '0;
        end else begin
            if (ovfEvt && !(&ovfCount)) ovfCount <= ovfCount + 16'd1;
            if (badEvt && !(&badCount)) badCount <= badCount + 8'd1;
        end
`else
    assign ovfCount = '0;
    assign badCount = '0;
`endif
endmodule
